// File: rtl/sram_rr_arbiter.sv
// Multi-channel SRAM arbiter: round-robin or fixed-priority grant,
// registered SRAM strobes and an in-order read-return tag pipeline.
module sram_rr_arbiter #(
    parameter int AW         = 19,
    parameter int DW         = 8,
    parameter int NCH        = 2,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRI  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH-1:0]    req_we,
    input  logic [NCH*AW-1:0] req_addr,
    input  logic [NCH*DW-1:0] req_wdata,
    output logic [NCH-1:0]    req_ready,
    output logic [DW-1:0]     rd_data,
    output logic [NCH-1:0]    rd_valid,
    output logic [AW-1:0]     sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DW-1:0]     sram_dat_wr,
    input  logic [DW-1:0]     sram_dat_rd
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef struct packed {
        logic          v;
        logic [IW-1:0] ch;
    } tag_t;

    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  w_gidx;
    logic           w_any;
    logic [NCH-1:0] w_gnt;
    logic           w_xfer;
    logic           w_rd;
    logic [DW-1:0]  r_rd_data;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_dat_wr;
    logic           r_ce_n;
    logic           r_oe_n;
    logic           r_we_n;
    tag_t           r_tag [RD_LATENCY+1];

    // Loops run from lowest to highest priority so the winner is written last
    always_comb begin
        w_gidx = '0;
        w_any  = 1'b0;
        if (FIXED_PRI != 0) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    w_gidx = IW'(i);
                    w_any  = 1'b1;
                end
            end
        end else begin
            for (int i = NCH; i >= 1; i--) begin
                if (req_valid[(int'(r_ptr) + i) % NCH]) begin
                    w_gidx = IW'((int'(r_ptr) + i) % NCH);
                    w_any  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_any && en && rst_n) begin
            w_gnt[w_gidx] = 1'b1;
        end
    end

    assign req_ready = w_gnt;
    assign w_xfer    = w_any && en && rst_n;
    assign w_rd      = w_xfer && !req_we[w_gidx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= IW'(NCH - 1);
            r_addr   <= '0;
            r_dat_wr <= '0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
        end else if (w_xfer) begin
            r_ptr    <= w_gidx;
            r_addr   <= req_addr[int'(w_gidx)*AW +: AW];
            r_dat_wr <= req_wdata[int'(w_gidx)*DW +: DW];
            r_ce_n   <= 1'b0;
            r_oe_n   <= req_we[w_gidx];
            r_we_n   <= !req_we[w_gidx];
        end else begin
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
        end
    end

    // Stage RD_LATENCY-1 lines up with the SRAM data; the last stage is rd_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            r_tag[0].v  <= w_rd;
            r_tag[0].ch <= w_gidx;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (r_tag[RD_LATENCY-1].v) begin
                r_rd_data <= sram_dat_rd;
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        if (r_tag[RD_LATENCY].v) begin
            rd_valid[r_tag[RD_LATENCY].ch] = 1'b1;
        end
    end

    assign rd_data     = r_rd_data;
    assign sram_addr   = r_addr;
    assign sram_dat_wr = r_dat_wr;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter: three configurations
// (2ch/RL1 with SRAM model, 4ch RR/RL3, 4ch fixed priority).
module tb_sram_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- instance A: NCH=2, RL=1 ----------------
    logic        a_rst_n, a_en;
    logic [1:0]  a_valid, a_we, a_ready, a_rd_valid;
    logic [37:0] a_addr;
    logic [15:0] a_wdata;
    logic [7:0]  a_rd_data, a_dw, a_dr;
    logic [18:0] a_sa;
    logic        a_ce, a_oe, a_wen;
    logic [7:0]  mem [0:255];

    sram_rr_arbiter #(.AW(19), .DW(8), .NCH(2), .RD_LATENCY(1),
                      .FIXED_PRI(0)) u_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en),
        .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr),
        .req_wdata(a_wdata), .req_ready(a_ready),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .sram_addr(a_sa), .sram_ce_n(a_ce), .sram_oe_n(a_oe),
        .sram_we_n(a_wen), .sram_dat_wr(a_dw), .sram_dat_rd(a_dr));

    assign a_dr = mem[a_sa[7:0]];
    always @(posedge clk) begin
        if (!a_ce && !a_wen) mem[a_sa[7:0]] <= a_dw;
    end

    // ---------------- instance B: NCH=4, RR, RL=3 ----------------
    logic        bc_rst_n, b_en;
    logic [3:0]  b_valid, b_we, b_ready, b_rd_valid;
    logic [75:0] b_addr;
    logic [31:0] b_wdata;
    logic [7:0]  b_rd_data, b_dw, b_dr, b_p1, b_p2;
    logic [18:0] b_sa;
    logic        b_ce, b_oe, b_wen;

    sram_rr_arbiter #(.AW(19), .DW(8), .NCH(4), .RD_LATENCY(3),
                      .FIXED_PRI(0)) u_b (
        .clk(clk), .rst_n(bc_rst_n), .en(b_en),
        .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
        .req_wdata(b_wdata), .req_ready(b_ready),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .sram_addr(b_sa), .sram_ce_n(b_ce), .sram_oe_n(b_oe),
        .sram_we_n(b_wen), .sram_dat_wr(b_dw), .sram_dat_rd(b_dr));

    // 3-cycle SRAM: data = addr[7:0]^0x3C, two extra register stages
    always @(posedge clk) begin
        b_p1 <= b_sa[7:0] ^ 8'h3C;
        b_p2 <= b_p1;
    end
    assign b_dr = b_p2;

    // ---------------- instance C: NCH=4, fixed priority ----------------
    logic        c_en;
    logic [3:0]  c_valid, c_we, c_ready, c_rd_valid;
    logic [75:0] c_addr;
    logic [31:0] c_wdata;
    logic [7:0]  c_rd_data, c_dw, c_dr;
    logic [18:0] c_sa;
    logic        c_ce, c_oe, c_wen;

    sram_rr_arbiter #(.AW(19), .DW(8), .NCH(4), .RD_LATENCY(1),
                      .FIXED_PRI(1)) u_c (
        .clk(clk), .rst_n(bc_rst_n), .en(c_en),
        .req_valid(c_valid), .req_we(c_we), .req_addr(c_addr),
        .req_wdata(c_wdata), .req_ready(c_ready),
        .rd_data(c_rd_data), .rd_valid(c_rd_valid),
        .sram_addr(c_sa), .sram_ce_n(c_ce), .sram_oe_n(c_oe),
        .sram_we_n(c_wen), .sram_dat_wr(c_dw), .sram_dat_rd(c_dr));

    assign c_dr = 8'h00;

    typedef struct {
        logic [3:0] v;
        logic       en;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [16];
    logic [3:0] exp_rv [5];

    initial begin
        // pointer starts at 3; each row's expected grant is hand-derived
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0100};
        tbl[7]  = '{4'b1111, 1'b1, 4'b1000};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000};
        tbl[9]  = '{4'b1010, 1'b1, 4'b0010};
        tbl[10] = '{4'b1010, 1'b0, 4'b0000};
        tbl[11] = '{4'b1010, 1'b1, 4'b1000};
        tbl[12] = '{4'b0110, 1'b1, 4'b0010};
        tbl[13] = '{4'b0001, 1'b1, 4'b0001};
        tbl[14] = '{4'b1001, 1'b1, 4'b1000};
        tbl[15] = '{4'b1001, 1'b1, 4'b0001};
        exp_rv[0] = 4'b0000;
        exp_rv[1] = 4'b0000;
        exp_rv[2] = 4'b0100;
        exp_rv[3] = 4'b0001;
        exp_rv[4] = 4'b0000;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        a_rst_n = 1'b0; bc_rst_n = 1'b0;
        a_en = 1'b1; a_valid = 2'b11; a_we = 2'b01;
        a_addr = {19'h00010, 19'h00010};
        a_wdata = {8'h00, 8'h5A};
        b_en = 1'b1; b_valid = 4'b1111; b_we = 4'b1111;
        b_addr = '0; b_wdata = '0;
        c_en = 1'b1; c_valid = 4'b0101; c_we = 4'b1111;
        c_addr = '0; c_wdata = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_ready", 32'(a_ready), 32'h0);
        chk("rst_a_rdvalid", 32'(a_rd_valid), 32'h0);
        chk("rst_a_rddata", 32'(a_rd_data), 32'h0);
        chk("rst_a_strobes", {29'h0, a_ce, a_oe, a_wen}, 32'h7);
        chk("rst_a_addr", 32'(a_sa), 32'h0);
        chk("rst_a_dw", 32'(a_dw), 32'h0);
        chk("rst_b_ready", 32'(b_ready), 32'h0);

        // round-robin table on B
        @(negedge clk);
        bc_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_valid = tbl[i].v;
            b_en    = tbl[i].en;
            #1;
            chk($sformatf("rr_row%0d", i), 32'(b_ready), 32'(tbl[i].exp));
            @(negedge clk);
        end

        // B: reads ch2 then ch0, then en low
        b_we = 4'b0000;
        b_addr[2*19 +: 19] = 19'h00123;
        b_addr[0 +: 19]    = 19'h000AB;
        b_en = 1'b1; b_valid = 4'b0100;
        #1 chk("rl3_gnt_ch2", 32'(b_ready), 32'h4);
        @(negedge clk);
        b_valid = 4'b0001;
        #1 chk("rl3_gnt_ch0", 32'(b_ready), 32'h1);
        @(negedge clk);
        b_en = 1'b0; b_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk($sformatf("rl3_noready%0d", j), 32'(b_ready), 32'h0);
            chk($sformatf("rl3_rdvalid%0d", j), 32'(b_rd_valid),
                32'(exp_rv[j]));
            if (j == 2) chk("rl3_data_ch2", 32'(b_rd_data), 32'h1F);
            if (j == 3) chk("rl3_data_ch0", 32'(b_rd_data), 32'h97);
            @(negedge clk);
        end

        // C: fixed priority, ch0 and ch2 always valid
        for (int j = 0; j < 6; j++) begin
            #1 chk($sformatf("fp_cyc%0d", j), 32'(c_ready), 32'h1);
            @(negedge clk);
        end
        c_valid = 4'b0100;
        #1 chk("fp_ch2_alone", 32'(c_ready), 32'h4);
        @(negedge clk);

        // A: ch0 write then ch1 read of the same address
        a_rst_n = 1'b1;
        #1 chk("a_first_gnt", 32'(a_ready), 32'h1);
        @(negedge clk);
        #1;
        chk("a_gnt_ch1", 32'(a_ready), 32'h2);
        chk("a_wr_addr", 32'(a_sa), 32'h10);
        chk("a_wr_strobes", {29'h0, a_ce, a_oe, a_wen}, 32'h2);
        chk("a_wr_data", 32'(a_dw), 32'h5A);
        chk("a_wr_nordv", 32'(a_rd_valid), 32'h0);
        @(negedge clk);
        a_valid = 2'b00;
        #1;
        chk("a_rd_strobes", {29'h0, a_ce, a_oe, a_wen}, 32'h1);
        chk("a_rd_nordv", 32'(a_rd_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("a_rdvalid", 32'(a_rd_valid), 32'h2);
        chk("a_rddata", 32'(a_rd_data), 32'h5A);
        @(negedge clk);
        #1;
        chk("a_rdvalid_pulse", 32'(a_rd_valid), 32'h0);
        chk("a_rddata_hold", 32'(a_rd_data), 32'h5A);
        chk("a_idle_strobes", {29'h0, a_ce, a_oe, a_wen}, 32'h7);
        chk("a_idle_addr", 32'(a_sa), 32'h10);

        // A: reset mid-read
        @(negedge clk);
        a_valid = 2'b10; a_we = 2'b00;
        #1 chk("a_rd2_gnt", 32'(a_ready), 32'h2);
        @(negedge clk);
        a_valid = 2'b00;
        a_rst_n = 1'b0;
        #1;
        chk("a_mid_strobes", {29'h0, a_ce, a_oe, a_wen}, 32'h7);
        chk("a_mid_addr", 32'(a_sa), 32'h0);
        chk("a_mid_rddata", 32'(a_rd_data), 32'h0);
        @(negedge clk);
        a_rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1 chk($sformatf("a_post_rst_rdv%0d", j),
                   32'(a_rd_valid), 32'h0);
            @(negedge clk);
        end
        a_valid = 2'b11;
        #1 chk("a_post_rst_gnt", 32'(a_ready), 32'h1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
